// File: rtl/uart_engine_if.sv
// Byte-level handshake bundle between the bus-side register block and the UART core.
interface uart_engine_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_parity_err;
  logic              rx_frame_err;
  logic              rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_engine.sv
// Full-duplex UART: oversampled receiver with 3-sample majority vote, optional parity,
// 1/2 stop bits, valid/ready byte handshakes and per-frame error reporting.
module uart_engine #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CBP_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CBP_W-1:0] cbp_i,
  input  logic [1:0]       parity_i,
  input  logic             stop2_i,
  output logic             tx_o,
  input  logic             rx_i,
  uart_engine_if.slave     bus
);

  localparam int TC_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [TC_W-1:0]  TC_LAST = TC_W'(OVERSAMPLE - 1);
  localparam logic [TC_W-1:0]  TC_MID  = TC_W'(OVERSAMPLE / 2);
  localparam logic [TC_W-1:0]  TC_MIDM = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0]  TC_MIDP = TC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;

  function automatic logic par_calc(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // ---------------- transmitter ----------------
  tx_state_e         r_tx_state, w_tx_next;
  logic [CBP_W-1:0]  r_tx_div;
  logic [TC_W-1:0]   r_tx_tcnt;
  logic [BIT_W-1:0]  r_tx_bit;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_tx_par_en, r_tx_par_bit, r_tx_stop2, r_tx_o;
  logic              w_tx_accept, w_tx_tick, w_tx_bit_end;

  assign w_tx_accept  = bus.tx_valid && (r_tx_state == TX_IDLE);
  assign w_tx_tick    = (r_tx_state != TX_IDLE) && (r_tx_div >= cbp_i);
  assign w_tx_bit_end = w_tx_tick && (r_tx_tcnt == TC_LAST);

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:   if (bus.tx_valid) w_tx_next = TX_START;
      TX_START:  if (w_tx_bit_end) w_tx_next = TX_DATA;
      TX_DATA:   if (w_tx_bit_end && (r_tx_bit == BIT_LAST))
                   w_tx_next = r_tx_par_en ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_tx_bit_end) w_tx_next = TX_STOP;
      TX_STOP:   if (w_tx_bit_end && (r_tx_bit == {{(BIT_W-1){1'b0}}, r_tx_stop2}))
                   w_tx_next = TX_IDLE;
      default:   w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_tx_state <= TX_IDLE;
    else         r_tx_state <= w_tx_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_tx_div     <= '0;
      r_tx_tcnt    <= '0;
      r_tx_bit     <= '0;
      r_tx_o       <= 1'b1;
      r_tx_par_en  <= 1'b0;
      r_tx_par_bit <= 1'b0;
      r_tx_stop2   <= 1'b0;
    end else if (w_tx_accept) begin
      r_tx_div     <= '0;
      r_tx_tcnt    <= '0;
      r_tx_bit     <= '0;
      r_tx_o       <= 1'b0;
      r_tx_par_en  <= parity_i[0] ^ parity_i[1];
      r_tx_par_bit <= par_calc(bus.tx_data, parity_i[1]);
      r_tx_stop2   <= stop2_i;
    end else if (w_tx_tick) begin
      r_tx_div  <= '0;
      r_tx_tcnt <= w_tx_bit_end ? '0 : r_tx_tcnt + 1'b1;
      // line value for the next bit is registered at the boundary so tx_o is glitch-free
      if (w_tx_bit_end) begin
        case (r_tx_state)
          TX_START: begin
            r_tx_o   <= r_tx_shift[0];
            r_tx_bit <= '0;
          end
          TX_DATA: begin
            if (r_tx_bit == BIT_LAST) begin
              r_tx_bit <= '0;
              r_tx_o   <= r_tx_par_en ? r_tx_par_bit : 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + 1'b1;
              r_tx_o   <= r_tx_shift[1];
            end
          end
          TX_PARITY: begin
            r_tx_bit <= '0;
            r_tx_o   <= 1'b1;
          end
          TX_STOP: begin
            r_tx_bit <= r_tx_bit + 1'b1;
            r_tx_o   <= 1'b1;
          end
          default: r_tx_o <= 1'b1;
        endcase
      end
    end else if (r_tx_state != TX_IDLE) begin
      r_tx_div <= r_tx_div + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_tx_accept)                                  r_tx_shift <= bus.tx_data;
    else if (w_tx_bit_end && (r_tx_state == TX_DATA)) r_tx_shift <= r_tx_shift >> 1;
  end

  assign tx_o         = r_tx_o;
  assign bus.tx_ready = (r_tx_state == TX_IDLE);

  // ---------------- receiver ----------------
  rx_state_e         r_rx_state, w_rx_next;
  logic              r_rx_s1, r_rx_s2;
  logic [CBP_W-1:0]  r_rx_div;
  logic [TC_W-1:0]   r_rx_tcnt;
  logic [BIT_W-1:0]  r_rx_bit;
  logic [DATA_W-1:0] r_rx_shift;
  logic              r_rx_par_en, r_rx_par_odd, r_rx_par_bit, r_rx_smp_a, r_rx_smp_b;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid, r_rx_perr, r_rx_ferr, r_rx_ovr;
  logic              w_rx_line, w_rx_tick, w_rx_bit_end, w_rx_mid, w_rx_vote_t, w_rx_vote;
  logic              w_rx_done, w_rx_accept, w_rx_perr;

  assign w_rx_line    = r_rx_s2;
  assign w_rx_tick    = (r_rx_state != RX_IDLE) && (r_rx_state != RX_BREAK) && (r_rx_div >= cbp_i);
  assign w_rx_bit_end = w_rx_tick && (r_rx_tcnt == TC_LAST);
  assign w_rx_mid     = w_rx_tick && (r_rx_tcnt == TC_MID);
  assign w_rx_vote_t  = w_rx_tick && (r_rx_tcnt == TC_MIDP);
  assign w_rx_vote    = maj3(r_rx_smp_a, r_rx_smp_b, w_rx_line);
  assign w_rx_done    = (r_rx_state == RX_STOP) && w_rx_vote_t;
  assign w_rx_accept  = r_rx_valid && bus.rx_ready;
  assign w_rx_perr    = r_rx_par_en && (r_rx_par_bit != par_calc(r_rx_shift, r_rx_par_odd));

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:   if (!w_rx_line) w_rx_next = RX_START;
      RX_START:  if (w_rx_mid && w_rx_line) w_rx_next = RX_IDLE;
                 else if (w_rx_bit_end)     w_rx_next = RX_DATA;
      RX_DATA:   if (w_rx_bit_end && (r_rx_bit == BIT_LAST))
                   w_rx_next = r_rx_par_en ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_bit_end) w_rx_next = RX_STOP;
      RX_STOP:   if (w_rx_vote_t) w_rx_next = w_rx_vote ? RX_IDLE : RX_BREAK;
      RX_BREAK:  if (w_rx_line) w_rx_next = RX_IDLE;
      default:   w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_rx_state <= RX_IDLE;
    else         r_rx_state <= w_rx_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_div     <= '0;
      r_rx_tcnt    <= '0;
      r_rx_bit     <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
    end else begin
      r_rx_s1 <= rx_i;
      r_rx_s2 <= r_rx_s1;
      if (r_rx_state == RX_IDLE) begin
        r_rx_div  <= '0;
        r_rx_tcnt <= '0;
        r_rx_bit  <= '0;
        if (!w_rx_line) begin
          r_rx_par_en  <= parity_i[0] ^ parity_i[1];
          r_rx_par_odd <= parity_i[1];
        end
      end else if (w_rx_tick) begin
        r_rx_div  <= '0;
        r_rx_tcnt <= w_rx_bit_end ? '0 : r_rx_tcnt + 1'b1;
        if (w_rx_bit_end && (r_rx_state == RX_DATA))
          r_rx_bit <= (r_rx_bit == BIT_LAST) ? '0 : r_rx_bit + 1'b1;
      end else if (r_rx_state != RX_BREAK) begin
        r_rx_div <= r_rx_div + 1'b1;
      end
    end
  end

  // three consecutive mid-bit samples feed the majority vote
  always_ff @(posedge clk_i) begin
    if (w_rx_tick && (r_rx_tcnt == TC_MIDM)) r_rx_smp_a <= w_rx_line;
    if (w_rx_mid)                            r_rx_smp_b <= w_rx_line;
    if (w_rx_vote_t && (r_rx_state == RX_DATA))   r_rx_shift   <= {w_rx_vote, r_rx_shift[DATA_W-1:1]};
    if (w_rx_vote_t && (r_rx_state == RX_PARITY)) r_rx_par_bit <= w_rx_vote;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      if (w_rx_done && (!r_rx_valid || w_rx_accept)) begin
        r_rx_data  <= r_rx_shift;
        r_rx_perr  <= w_rx_perr;
        r_rx_ferr  <= !w_rx_vote;
        r_rx_valid <= 1'b1;
      end else if (w_rx_accept) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_done && r_rx_valid && !w_rx_accept) r_rx_ovr <= 1'b1;
      else if (w_rx_accept)                        r_rx_ovr <= 1'b0;
    end
  end

  assign bus.rx_data       = r_rx_data;
  assign bus.rx_valid      = r_rx_valid;
  assign bus.rx_parity_err = r_rx_perr;
  assign bus.rx_frame_err  = r_rx_ferr;
  assign bus.rx_overrun    = r_rx_ovr;

endmodule

// File: tb/tb_uart_engine.sv
// Directed plus randomized bench for uart_engine: loopback and directly driven RX frames
// checked against a bit-list model of the serial frame format.
module tb_uart_engine;
  localparam int DW = 8;
  localparam int OS = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] cbp = '0;
  logic [1:0]    par = 2'b00;
  logic          stop2 = 1'b0;
  logic          tx_o;
  logic          rx_line;
  logic          drv_rx = 1'b1;
  logic          loop_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  uart_engine_if #(.DATA_W(DW)) u_if();

  assign rx_line = loop_en ? tx_o : drv_rx;

  uart_engine #(.DATA_W(DW), .OVERSAMPLE(OS), .CBP_W(CW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .cbp_i    (cbp),
    .parity_i (par),
    .stop2_i  (stop2),
    .tx_o     (tx_o),
    .rx_i     (rx_line),
    .bus      (u_if)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected wire bit list of one frame, start bit first.
  task automatic build_frame(input logic [7:0] d, input logic [1:0] pm, input logic pflip,
                             input logic stop_v, input logic s2, output bit bq[$]);
    bq = {};
    bq.push_back(1'b0);
    for (int i = 0; i < DW; i++) bq.push_back(d[i]);
    if (pm == 2'b01) bq.push_back((^d) ^ pflip);
    if (pm == 2'b10) bq.push_back((~^d) ^ pflip);
    bq.push_back(stop_v);
    if (s2) bq.push_back(1'b1);
  endtask

  task automatic tx_loop_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                               input int cb, input string tag);
    bit bq[$];
    int t, bt, len, bad_o, bad_r;
    build_frame(d, pm, 1'b0, 1'b1, s2, bq);
    cbp = CW'(cb); par = pm; stop2 = s2; loop_en = 1'b1;
    t = 0;
    while (!u_if.tx_ready && t < 5000) begin step(); t++; end
    chk({tag, "_rdy_pre"}, u_if.tx_ready, 1);
    u_if.tx_data  = d;
    u_if.tx_valid = 1'b1;
    step();
    u_if.tx_valid = 1'b0;
    bt = OS * (cb + 1);
    len = bq.size() * bt;
    bad_o = 0; bad_r = 0;
    for (int j = 0; j < len; j++) begin
      if (j > 0) step();
      if (tx_o !== bq[j / bt]) bad_o++;
      if (u_if.tx_ready !== 1'b0) bad_r++;
    end
    chk({tag, "_wave_err_clks"}, bad_o, 0);
    chk({tag, "_busy_err_clks"}, bad_r, 0);
    step();
    chk({tag, "_rdy_post"}, u_if.tx_ready, 1);
    chk({tag, "_idle_line"}, tx_o, 1);
  endtask

  task automatic rx_drive(input logic [7:0] d, input logic [1:0] pm, input logic pflip,
                          input logic stop_v, input int gbit, input int gstart);
    bit bq[$];
    int bt, tk;
    build_frame(d, pm, pflip, stop_v, 1'b0, bq);
    loop_en = 1'b0;
    tk = int'(cbp) + 1;
    bt = OS * tk;
    for (int i = 0; i < bq.size(); i++) begin
      for (int c = 0; c < bt; c++) begin
        drv_rx = bq[i] ^ ((i == gbit) && (c >= gstart) && (c < gstart + tk));
        step();
      end
    end
  endtask

  task automatic rx_expect(input logic [7:0] d, input logic pe, input logic fe, input logic ov,
                           input string tag);
    int t;
    t = 0;
    while (!u_if.rx_valid && t < 6000) begin step(); t++; end
    chk({tag, "_valid"}, u_if.rx_valid, 1);
    chk({tag, "_data"}, u_if.rx_data, d);
    chk({tag, "_perr"}, u_if.rx_parity_err, pe);
    chk({tag, "_ferr"}, u_if.rx_frame_err, fe);
    chk({tag, "_ovr"}, u_if.rx_overrun, ov);
  endtask

  task automatic rx_accept(input string tag);
    u_if.rx_ready = 1'b1;
    step();
    u_if.rx_ready = 1'b0;
    chk({tag, "_valid_clr"}, u_if.rx_valid, 0);
    chk({tag, "_ovr_clr"}, u_if.rx_overrun, 0);
  endtask

  task automatic idle(input int n);
    drv_rx = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] pm;
    logic       s2, fl;
    int         cb, bt;

    u_if.tx_data  = '0;
    u_if.tx_valid = 1'b0;
    u_if.rx_ready = 1'b0;

    // reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_tx_o", tx_o, 1);
    chk("rst_tx_ready", u_if.tx_ready, 1);
    chk("rst_rx_valid", u_if.rx_valid, 0);
    chk("rst_rx_data", u_if.rx_data, 0);
    chk("rst_perr", u_if.rx_parity_err, 0);
    chk("rst_ferr", u_if.rx_frame_err, 0);
    chk("rst_ovr", u_if.rx_overrun, 0);
    rst_n = 1'b1;
    step();

    // T1: 8N1 loopback
    tx_loop_frame(8'hA5, 2'b00, 1'b0, 0, "t1");
    rx_expect(8'hA5, 1'b0, 1'b0, 1'b0, "t1_rx");
    rx_accept("t1_acc");

    // T2: even parity on the wire, then a forced bad parity bit
    tx_loop_frame(8'h07, 2'b01, 1'b0, 0, "t2");
    rx_expect(8'h07, 1'b0, 1'b0, 1'b0, "t2_rx");
    rx_accept("t2_acc");
    par = 2'b01;
    rx_drive(8'h07, 2'b01, 1'b1, 1'b1, -1, 0);
    rx_expect(8'h07, 1'b1, 1'b0, 1'b0, "t2_bad");
    rx_accept("t2_bad_acc");
    idle(32);

    // T3: framing error, line held low afterwards
    par = 2'b00; cbp = 1; bt = OS * 2;
    rx_drive(8'h3C, 2'b00, 1'b0, 1'b0, -1, 0);
    rx_expect(8'h3C, 1'b0, 1'b1, 1'b0, "t3");
    rx_accept("t3_acc");
    repeat (3 * bt) step();
    chk("t3_nostart_low", u_if.rx_valid, 0);
    idle(bt);
    rx_drive(8'h5A, 2'b00, 1'b0, 1'b1, -1, 0);
    rx_expect(8'h5A, 1'b0, 1'b0, 1'b0, "t3_after");
    rx_accept("t3_after_acc");
    idle(bt);

    // T4: short start pulse, then a one-tick glitch inside data bit 3
    drv_rx = 1'b0;
    repeat (4 * 2) step();
    idle(2 * bt);
    chk("t4_false_start", u_if.rx_valid, 0);
    rx_drive(8'h55, 2'b00, 1'b0, 1'b1, 4, 9 * 2);
    rx_expect(8'h55, 1'b0, 1'b0, 1'b0, "t4_glitch");
    rx_accept("t4_acc");
    idle(bt);

    // T5: overrun while the first frame is held
    cbp = 0; bt = OS;
    rx_drive(8'h11, 2'b00, 1'b0, 1'b1, -1, 0);
    rx_drive(8'h22, 2'b00, 1'b0, 1'b1, -1, 0);
    idle(4);
    rx_expect(8'h11, 1'b0, 1'b0, 1'b1, "t5");
    rx_accept("t5_acc");
    idle(bt);

    // T6: reset in the middle of TX and RX data
    cbp = 1; bt = OS * 2; par = 2'b00; stop2 = 1'b0; loop_en = 1'b0;
    u_if.tx_data  = 8'hC3;
    u_if.tx_valid = 1'b1;
    step();
    u_if.tx_valid = 1'b0;
    drv_rx = 1'b0;
    repeat (bt) step();
    drv_rx = 1'b1;
    repeat (2 * bt) step();
    rst_n = 1'b0;
    step();
    drv_rx = 1'b1;
    chk("t6_tx_o", tx_o, 1);
    chk("t6_tx_ready", u_if.tx_ready, 1);
    chk("t6_rx_valid", u_if.rx_valid, 0);
    rst_n = 1'b1;
    repeat (12 * bt) step();
    chk("t6_no_partial", u_if.rx_valid, 0);
    tx_loop_frame(8'h96, 2'b00, 1'b0, 1, "t6_resend");
    rx_expect(8'h96, 1'b0, 1'b0, 1'b0, "t6_rx");
    rx_accept("t6_acc");

    // randomized loopback frames
    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      pm = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      cb = int'($urandom_range(0, 2));
      tx_loop_frame(d, pm, s2, cb, $sformatf("rnd_tx%0d", k));
      rx_expect(d, 1'b0, 1'b0, 1'b0, $sformatf("rnd_tx%0d_rx", k));
      rx_accept($sformatf("rnd_tx%0d_acc", k));
    end

    // randomized directly driven frames with optional parity corruption
    for (int k = 0; k < 5; k++) begin
      d  = 8'($urandom);
      pm = 2'($urandom_range(0, 3));
      fl = 1'($urandom_range(0, 1));
      cbp = CW'($urandom_range(0, 2));
      par = pm;
      idle(OS * (int'(cbp) + 1));
      rx_drive(d, pm, fl, 1'b1, -1, 0);
      rx_expect(d, fl && (pm == 2'b01 || pm == 2'b10), 1'b0, 1'b0, $sformatf("rnd_rx%0d", k));
      rx_accept($sformatf("rnd_rx%0d_acc", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
